// File: rtl/stereo_pan_mixer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pan_pkg                                                   |
// | Desc     : Shared types and constants for stereo_pan_mixer           |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package pan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_L = 2'd1,
    MUL_R = 2'd2,
    OUT   = 2'd3
  } pan_state_t;

  localparam logic [15:0] PAN_MAX    = 16'h7FFF;
  localparam logic [15:0] PAN_CENTER = 16'h4000;

  typedef logic signed [15:0] sample_t;
  typedef logic        [15:0] gain_t;

  // Pan words with bit 15 set are out of range and pin to hard right
  function automatic gain_t pan_clamp(input gain_t p);
    return p[15] ? PAN_MAX : p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stereo_pan_mixer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : stereo_pan_mixer_if                                       |
// | Desc     : Sample/pan in, stereo pair out, with strobes and busy     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface stereo_pan_mixer_if;
  import pan_pkg::*;

  sample_t SAMPLE_IN;
  logic    SAMPLE_VALID;
  gain_t   PAN_IN;
  sample_t LEFT_OUT;
  sample_t RIGHT_OUT;
  logic    OUT_VALID;
  logic    BUSY;

  modport master (
    output SAMPLE_IN, SAMPLE_VALID, PAN_IN,
    input  LEFT_OUT, RIGHT_OUT, OUT_VALID, BUSY
  );

  modport slave (
    input  SAMPLE_IN, SAMPLE_VALID, PAN_IN,
    output LEFT_OUT, RIGHT_OUT, OUT_VALID, BUSY
  );

endinterface
`default_nettype wire

// File: rtl/stereo_pan_mixer_slew.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pan_slew                                                  |
// | Desc     : Pan target clamp with optional slew limiter. With macro   |
// |            PAN_SLEW_EN defined the applied pan moves at most         |
// |            SLEW_STEP per accept; otherwise it follows the clamped    |
// |            target directly.                                          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module pan_slew
  import pan_pkg::*;
#(
  parameter gain_t SLEW_STEP = 16'h0040
) (
  input  logic  clk_i,
  input  logic  rst_n_i,
  input  logic  accept_i,
  input  gain_t target_i,
  output gain_t pan_cur_o
);

  gain_t w_target;
  gain_t pan_d;
  gain_t pan_q;

  assign w_target = pan_clamp(target_i);

`ifdef PAN_SLEW_EN
  // Step toward the target; snap when within one step so it never overshoots
  always_comb begin
    pan_d = pan_q;
    if (w_target > pan_q) begin
      pan_d = ((w_target - pan_q) <= SLEW_STEP) ? w_target : (pan_q + SLEW_STEP);
    end else if (w_target < pan_q) begin
      pan_d = ((pan_q - w_target) <= SLEW_STEP) ? w_target : (pan_q - SLEW_STEP);
    end
  end
`else
  gain_t unused_slew_step;
  assign unused_slew_step = SLEW_STEP;

  // Without slew limiting the applied pan is simply the clamped target
  always_comb begin
    pan_d = w_target;
  end
`endif

  // Applied pan register, updated only when a sample is accepted
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pan_q <= PAN_CENTER;
    end else if (accept_i) begin
      pan_q <= pan_d;
    end
  end

  assign pan_cur_o = pan_q;

endmodule
`default_nettype wire

// File: rtl/stereo_pan_mixer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : stereo_pan_mixer                                          |
// | Desc     : Applies a Q15 pan word to a mono sample, producing a      |
// |            left/right pair with one shared multiplier. Optional      |
// |            pan slew limiting is enabled by macro PAN_SLEW_EN.        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module stereo_pan_mixer
  import pan_pkg::*;
#(
  parameter gain_t SLEW_STEP = 16'h0040
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET,
  stereo_pan_mixer_if.slave        bus
);

  pan_state_t         state_q;
  sample_t            sample_q;
  sample_t            hold_l_q;
  sample_t            left_q;
  sample_t            right_q;
  logic               valid_q;
  logic               busy_q;

  logic               w_accept;
  gain_t              w_pan_cur;
  gain_t              w_gain;
  logic signed [32:0] w_prod;
  sample_t            w_res;
  logic               unused_prod_bits;

  assign w_accept = (state_q == IDLE) && bus.SAMPLE_VALID;

  pan_slew #(
    .SLEW_STEP (SLEW_STEP)
  ) u_pan_slew (
    .clk_i     (CLOCK_50),
    .rst_n_i   (RESET),
    .accept_i  (w_accept),
    .target_i  (bus.PAN_IN),
    .pan_cur_o (w_pan_cur)
  );

  // Shared multiplier: left gain in MUL_L, right gain otherwise.
  // Gain is below 1.0, so bits [30:15] always hold the full result.
  assign w_gain           = (state_q == MUL_L) ? (PAN_MAX - w_pan_cur) : w_pan_cur;
  assign w_prod           = $signed({1'b0, w_gain}) * sample_q;
  assign w_res            = w_prod[30:15];
  assign unused_prod_bits = ^{w_prod[32:31], w_prod[14:0]};

  // Sequencer: accept -> left product -> right product -> present pair.
  // The output registers load on entry to OUT so the pair and OUT_VALID
  // appear in the same cycle.
  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      sample_q <= '0;
      hold_l_q <= '0;
      left_q   <= '0;
      right_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.SAMPLE_VALID) begin
            sample_q <= bus.SAMPLE_IN;
            busy_q   <= 1'b1;
            state_q  <= MUL_L;
          end
        end
        MUL_L: begin
          hold_l_q <= w_res;
          state_q  <= MUL_R;
        end
        MUL_R: begin
          left_q  <= hold_l_q;
          right_q <= w_res;
          valid_q <= 1'b1;
          state_q <= OUT;
        end
        OUT: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.LEFT_OUT  = left_q;
  assign bus.RIGHT_OUT = right_q;
  assign bus.OUT_VALID = valid_q;
  assign bus.BUSY      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_stereo_pan_mixer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_stereo_pan_mixer                                       |
// | Desc     : Self-checking bench for stereo_pan_mixer against an       |
// |            arithmetic reference model (PAN_SLEW_EN aware).           |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_stereo_pan_mixer;
  import pan_pkg::*;

  localparam int STEP = 64;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m_pan   = 16'h4000;
  logic [15:0] m_left  = 16'h0000;
  logic [15:0] m_right = 16'h0000;

  stereo_pan_mixer_if bus();

  stereo_pan_mixer #(
    .SLEW_STEP (16'(STEP))
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: applied pan after one accepted sample with target tgt
  function automatic logic [15:0] model_next_pan(input logic [15:0] cur, input logic [15:0] tgt);
    int t;
    int c;
    t = (tgt > 16'h7FFF) ? 32767 : int'(tgt);
    c = int'(cur);
`ifdef PAN_SLEW_EN
    if (t - c > STEP)      c = c + STEP;
    else if (c - t > STEP) c = c - STEP;
    else                   c = t;
`else
    c = t;
`endif
    return 16'(c);
  endfunction

  // Reference: floor(sample * gain / 32768)
  function automatic logic [15:0] model_scale(input logic [15:0] s, input int gain);
    longint p;
    p = longint'($signed(s)) * longint'(gain);
    return 16'(p >>> 15);
  endfunction

  task automatic check_cycle(input string tag, input logic busy, input logic ov);
    check({tag, "_busy"},  {15'd0, bus.BUSY},      {15'd0, busy});
    check({tag, "_valid"}, {15'd0, bus.OUT_VALID}, {15'd0, ov});
    check({tag, "_left"},  bus.LEFT_OUT,           m_left);
    check({tag, "_right"}, bus.RIGHT_OUT,          m_right);
  endtask

  // Strobe one sample; optionally raise a stray strobe in cycle drop_k (1..3)
  task automatic run_sample(input logic [15:0] s, input logic [15:0] p, input int drop_k);
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    m_pan = model_next_pan(m_pan, p);
    exp_l = model_scale(s, 32767 - int'(m_pan));
    exp_r = model_scale(s, int'(m_pan));
    bus.SAMPLE_IN    = s;
    bus.PAN_IN       = p;
    bus.SAMPLE_VALID = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      bus.SAMPLE_VALID = 1'b0;
      bus.SAMPLE_IN    = 16'($urandom);
      bus.PAN_IN       = 16'($urandom);
      if (k == 3) begin
        m_left  = exp_l;
        m_right = exp_r;
      end
      check_cycle("smp", k <= 3, k == 3);
      if (k == drop_k) bus.SAMPLE_VALID = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      check_cycle("idle", 1'b0, 1'b0);
    end
  endtask

  initial begin
    bus.SAMPLE_IN    = '0;
    bus.SAMPLE_VALID = 1'b0;
    bus.PAN_IN       = 16'h4000;

    // Reset state
    #1;
    check_cycle("reset", 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Centre pan
    run_sample(16'h4000, 16'h4000, 0);
    check("centre_L", bus.LEFT_OUT,  16'h1FFF);
    check("centre_R", bus.RIGHT_OUT, 16'h2000);

    // Hard pans, clamp and negative truncation
    run_sample(16'h7FFF, 16'h0000, 0);
`ifndef PAN_SLEW_EN
    check("hardL_L", bus.LEFT_OUT,  16'h7FFE);
    check("hardL_R", bus.RIGHT_OUT, 16'h0000);
`endif
    run_sample(16'h8000, 16'h7FFF, 0);
`ifndef PAN_SLEW_EN
    check("hardR_L", bus.LEFT_OUT,  16'h0000);
    check("hardR_R", bus.RIGHT_OUT, 16'h8001);
`endif
    run_sample(16'h8000, 16'hFFFF, 0);
`ifndef PAN_SLEW_EN
    check("clamp_R", bus.RIGHT_OUT, 16'h8001);
`endif
    idle(1);
    run_sample(16'hFFFF, 16'h4000, 0);
`ifndef PAN_SLEW_EN
    check("neg_L", bus.LEFT_OUT,  16'hFFFF);
    check("neg_R", bus.RIGHT_OUT, 16'hFFFF);
`endif

    // Strobes while busy are dropped; strobe four cycles later is accepted
    run_sample(16'h1234, 16'h2000, 2);
    run_sample(16'hABCD, 16'h6000, 1);
    run_sample(16'h5555, 16'h1000, 3);
    idle(2);

    // Randomised traffic
    for (int i = 0; i < 40; i++) begin
      run_sample(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
      idle(int'($urandom_range(0, 2)));
    end

    // Reset while in MUL_R discards the sample
    bus.SAMPLE_IN    = 16'h7FFF;
    bus.PAN_IN       = 16'h7FFF;
    bus.SAMPLE_VALID = 1'b1;
    @(posedge clk); #1;
    bus.SAMPLE_VALID = 1'b0;
    @(posedge clk); #1;
    rst_n   = 1'b0;
    m_pan   = 16'h4000;
    m_left  = 16'h0000;
    m_right = 16'h0000;
    #1;
    check_cycle("midrst", 1'b0, 1'b0);
    @(posedge clk); #1;
    check_cycle("midrst_hold", 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(3);
`ifdef PAN_SLEW_EN
    run_sample(16'h7FFF, 16'h4000, 0);
    check("post_rst_R", bus.RIGHT_OUT, 16'h3FFF);
    // Slew from centre to hard right takes 256 accepted samples
    for (int i = 0; i < 256; i++) begin
      run_sample(16'h7FFF, 16'h7FFF, 0);
    end
    check("slew_end_L", bus.LEFT_OUT,  16'h0000);
    check("slew_end_R", bus.RIGHT_OUT, 16'h7FFE);
    run_sample(16'h7FFF, 16'h7FFF, 0);
    check("slew_hold_R", bus.RIGHT_OUT, 16'h7FFE);
`else
    run_sample(16'h7FFF, 16'h4000, 0);
    check("post_rst_L", bus.LEFT_OUT,  16'h3FFE);
    check("post_rst_R", bus.RIGHT_OUT, 16'h3FFF);
`endif
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
